// File: rtl/seq_alu_pkg.sv
// Shared op codes and FSM state encoding for the registered sequential ALU.
package seq_alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_SLTU  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one
// accumulator, shift register and iteration counter.
module seq_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             op,
  input  logic             run,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt,
  output logic [WIDTH-1:0] dvd
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] opnd_q;
  logic             op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   sub_w;

  assign dvd  = sreg_q;
  assign done = run && (cnt_q == CNT_W'(WIDTH - 1));

  // One iteration: {acc,sreg} forms the product (mul) or remainder:quotient (div)
  always_comb begin
    add_w  = {1'b0, acc_q} + {1'b0, opnd_q};
    shl_w  = {acc_q, sreg_q[WIDTH-1]};
    sub_w  = shl_w - {1'b0, opnd_q};
    hi_nxt = acc_q;
    lo_nxt = sreg_q;
    if (!op_q) begin
      if (sreg_q[0]) begin
        hi_nxt = add_w[WIDTH:1];
        lo_nxt = {add_w[0], sreg_q[WIDTH-1:1]};
      end else begin
        hi_nxt = {1'b0, acc_q[WIDTH-1:1]};
        lo_nxt = {acc_q[0], sreg_q[WIDTH-1:1]};
      end
    end else if (!sub_w[WIDTH]) begin
      hi_nxt = sub_w[WIDTH-1:0];
      lo_nxt = {sreg_q[WIDTH-2:0], 1'b1};
    end else begin
      hi_nxt = shl_w[WIDTH-1:0];
      lo_nxt = {sreg_q[WIDTH-2:0], 1'b0};
    end
  end

  // Datapath registers: contents are don't-care until the next load
  always_ff @(posedge clk) begin
    if (load) begin
      acc_q  <= '0;
      sreg_q <= op ? a : b;
      opnd_q <= op ? b : a;
    end else if (run) begin
      acc_q  <= hi_nxt;
      sreg_q <= lo_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= 1'b0;
      cnt_q <= '0;
    end else if (load) begin
      op_q  <= op;
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with start/busy/done handshake and iterative MULTU/DIVU.
// Optional signed ADD/SUB overflow flag when SEQ_ALU_OVERFLOW_EN is defined.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic [WIDTH-1:0] aluresult,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
`ifdef SEQ_ALU_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  state_t                  state_q, state_d;
  logic                    md_load, md_op, md_run, md_done;
  logic                    issue_single, dz_issue, dz_q;
  logic [WIDTH-1:0]        md_hi, md_lo, md_dvd;
  logic [WIDTH-1:0]        sum_p0, diff_p0, res_p0;
  logic signed [WIDTH-1:0] sa_p0, sb_p0;

  assign sa_p0   = srca;
  assign sb_p0   = srcb;
  assign sum_p0  = srca + srcb;
  assign diff_p0 = srca - srcb;
  assign md_run  = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign busy    = md_run;

  always_comb begin
    res_p0 = '0;
    case (alucontrol)
      OP_AND:  res_p0 = srca & srcb;
      OP_OR:   res_p0 = srca | srcb;
      OP_ADD:  res_p0 = sum_p0;
      OP_SUB:  res_p0 = diff_p0;
      OP_XOR:  res_p0 = srca ^ srcb;
      OP_NOR:  res_p0 = ~(srca | srcb);
      OP_SLT:  res_p0 = {{(WIDTH-1){1'b0}}, (sa_p0 < sb_p0)};
      OP_SLTU: res_p0 = {{(WIDTH-1){1'b0}}, (srca < srcb)};
      default: res_p0 = '0;
    endcase
  end

`ifdef SEQ_ALU_OVERFLOW_EN
  logic ovf_p0;

  function automatic logic add_ovf(input logic [WIDTH-1:0] a, b, s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic [WIDTH-1:0] a, b, d);
    return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
  endfunction

  always_comb begin
    ovf_p0 = 1'b0;
    if (alucontrol == OP_ADD) ovf_p0 = add_ovf(srca, srcb, sum_p0);
    else if (alucontrol == OP_SUB) ovf_p0 = sub_ovf(srca, srcb, diff_p0);
  end
`endif

  // Next state; divide-by-zero bypasses DIV and finishes a cycle later via FIN
  always_comb begin
    state_d      = state_q;
    md_load      = 1'b0;
    md_op        = 1'b0;
    issue_single = 1'b0;
    dz_issue     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (alucontrol == OP_MULTU) begin
            md_load = 1'b1;
            state_d = ST_MUL;
          end else if (alucontrol == OP_DIVU) begin
            md_load = 1'b1;
            md_op   = 1'b1;
            if (srcb == '0) begin
              dz_issue = 1'b1;
              state_d  = ST_FIN;
            end else begin
              state_d = ST_DIV;
            end
          end else begin
            issue_single = 1'b1;
          end
        end
      end
      ST_MUL, ST_DIV: if (md_done) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  seq_muldiv #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .load   (md_load),
    .op     (md_op),
    .run    (md_run),
    .a      (srca),
    .b      (srcb),
    .done   (md_done),
    .hi_nxt (md_hi),
    .lo_nxt (md_lo),
    .dvd    (md_dvd)
  );

  // Result registers: aluresult/zero/done (and overflow) always update together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      aluresult <= '0;
      zero      <= 1'b1;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      dz_q      <= 1'b0;
`ifdef SEQ_ALU_OVERFLOW_EN
      overflow  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      if (md_load) dz_q <= dz_issue;
      if (issue_single) begin
        aluresult <= res_p0;
        zero      <= (res_p0 == '0);
        done      <= 1'b1;
`ifdef SEQ_ALU_OVERFLOW_EN
        overflow  <= ovf_p0;
`endif
      end else if (md_done) begin
        hi        <= md_hi;
        lo        <= md_lo;
        aluresult <= md_lo;
        zero      <= (md_lo == '0);
        done      <= 1'b1;
`ifdef SEQ_ALU_OVERFLOW_EN
        overflow  <= 1'b0;
`endif
      end else if ((state_q == ST_FIN) && dz_q) begin
        hi        <= md_dvd;
        lo        <= '1;
        aluresult <= '1;
        zero      <= 1'b0;
        done      <= 1'b1;
`ifdef SEQ_ALU_OVERFLOW_EN
        overflow  <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expected results are queued at issue and
// checked (value, latency, busy length) when done pulses.
module tb_seq_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [3:0]   alucontrol;
  logic [W-1:0] srca, srcb, aluresult, hi, lo;
  logic         zero, busy, done;
`ifdef SEQ_ALU_OVERFLOW_EN
  logic         overflow;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         ovf;
    int           lat;
    int           bsy;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alucontrol (alucontrol),
    .srca       (srca),
    .srcb       (srcb),
    .aluresult  (aluresult),
    .zero       (zero),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done)
`ifdef SEQ_ALU_OVERFLOW_EN
    ,
    .overflow   (overflow)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [2*W-1:0] p;
    e.hi = m_hi; e.lo = m_lo; e.ovf = 1'b0; e.lat = 1; e.bsy = 0; e.res = '0;
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: begin
        e.res = a + b;
        e.ovf = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      4'b0110: begin
        e.res = a - b;
        e.ovf = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      4'b0100: e.res = a ^ b;
      4'b0101: e.res = ~(a | b);
      4'b0111: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1111: e.res = (a < b) ? 1 : 0;
      4'b1000: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.hi = p[2*W-1:W]; e.lo = p[W-1:0]; e.res = e.lo; e.lat = W + 1; e.bsy = W;
      end
      4'b1001: begin
        if (b == '0) begin
          e.hi = a; e.lo = '1; e.lat = 2; e.bsy = 0;
        end else begin
          e.hi = a % b; e.lo = a / b; e.lat = W + 1; e.bsy = W;
        end
        e.res = e.lo;
      end
      default: e.res = '0;
    endcase
    return e;
  endfunction

  // Issue one op; optionally fire a second start with other operands at cycle inj
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int inj);
    exp_t e, g;
    int   n, nb, extra;
    bit   seen;
    e = model(op, a, b);
    m_hi = e.hi; m_lo = e.lo;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b1; alucontrol = op; srca = a; srcb = b;
    n = 0; nb = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (n == 1) begin
        srca = $urandom; srcb = $urandom;
      end
      if (n == inj) begin
        start = 1'b1; alucontrol = 4'b1000; srca = 32'd3; srcb = 32'd5;
      end
      if (busy) nb++;
      if (busy && done) chk({tag, ".busy_and_done"}, 1, 0);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk({tag, ".done_seen"}, seen, 1);
    g = sb_q.pop_front();
    if (seen) begin
      chk({tag, ".latency"}, n, g.lat);
      chk({tag, ".busy_cycles"}, nb, g.bsy);
      chk({tag, ".aluresult"}, aluresult, g.res);
      chk({tag, ".zero"}, zero, (g.res == '0));
      chk({tag, ".hi"}, hi, g.hi);
      chk({tag, ".lo"}, lo, g.lo);
`ifdef SEQ_ALU_OVERFLOW_EN
      chk({tag, ".overflow"}, overflow, g.ovf);
`endif
    end
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk({tag, ".single_done"}, extra, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".aluresult"}, aluresult, 0);
    chk({tag, ".zero"}, zero, 1);
    chk({tag, ".hi"}, hi, 0);
    chk({tag, ".lo"}, lo, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
`ifdef SEQ_ALU_OVERFLOW_EN
    chk({tag, ".overflow"}, overflow, 0);
`endif
  endtask

  initial begin
    exp_t e;
    int   nd;
    reset = 1'b1; start = 1'b0; alucontrol = '0; srca = '0; srcb = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst0");
    reset = 1'b0;

    run_op("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'd1, -1);
    run_op("sub_zero", 4'b0110, 32'd5, 32'd5, -1);
    run_op("slt",      4'b0111, 32'hFFFF_FFFF, 32'd1, -1);
    run_op("sltu",     4'b1111, 32'hFFFF_FFFF, 32'd1, -1);
    run_op("illegal",  4'b0011, 32'h1234_5678, 32'h1111_1111, -1);
    run_op("and",      4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, -1);
    run_op("or",       4'b0001, 32'hF000_0001, 32'h0000_1000, -1);
    run_op("xor",      4'b0100, 32'hAAAA_5555, 32'hFFFF_0000, -1);
    run_op("nor",      4'b0101, 32'hAAAA_0000, 32'h5555_0000, -1);
    run_op("sub_ovf",  4'b0110, 32'h8000_0000, 32'd1, -1);
    run_op("multu_max", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op("and_keep_hilo", 4'b0000, 32'h1, 32'h1, -1);
    run_op("divu",     4'b1001, 32'd100, 32'd7, -1);
    run_op("divu_zero", 4'b1001, 32'd9, 32'd0, -1);
    run_op("multu_inj", 4'b1000, 32'd1234, 32'd5678, 5);
    run_op("divu_fin_inj", 4'b1001, 32'hDEAD_BEEF, 32'd3, W + 1);
    for (int i = 0; i < 2; i++) begin
      run_op("multu_rnd", 4'b1000, $urandom, $urandom, -1);
      run_op("divu_rnd", 4'b1001, $urandom, $urandom_range(1, 32'hFFFF), -1);
    end

    // Abort a divide mid-flight with an asynchronous reset
    e = model(4'b1001, 32'd1000, 32'd3);
    @(negedge clk);
    start = 1'b1; alucontrol = 4'b1001; srca = 32'd1000; srcb = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort.busy_before", busy, 1);
    #1 reset = 1'b1;
    #1 chk_reset_vals("abort");
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("abort.no_done", nd, 0);
    chk("abort.discarded_lo", lo, 0);
    run_op("add_after", 4'b0010, 32'd2, 32'd3, -1);
    if (e.lo == lo) chk("abort.result_leaked", lo, 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
